// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-control bundle between the ID-stage hazard scoreboard and the pipeline registers.
// master = pipeline side driving ID/EX/MEM status, slave = hazard_scoreboard_unit.
interface hazard_scoreboard_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_load;
    logic [REG_W-1:0] id_rd;
    logic             mem_busy;
    logic             ex_branch_taken;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_flush;
    logic [CNT_W-1:0] load_stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_load, id_rd,
               mem_busy, ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, load_stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_load, id_rd,
               mem_busy, ex_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, load_stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard controller: shift-register scoreboard of in-flight loads plus freeze/flush arbitration.
// Optional macro HAZ_ZERO_REG_EN: register 0 never participates in hazard detection.
module hazard_scoreboard_unit #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input logic                    clk,
    input logic                    reset,
    hazard_scoreboard_unit_if.slave hz
);
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } slot_t;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_STALL,
        MODE_FLUSH,
        MODE_FREEZE
    } mode_e;

    slot_t            slots [LOAD_LAT];
    slot_t            new_entry;
    logic             rs_ok;
    logic             rt_ok;
    logic             hazard;
    mode_e            mode;
    logic [CNT_W-1:0] stall_cnt;

`ifdef HAZ_ZERO_REG_EN
    assign rs_ok = (hz.id_rs != '0);
    assign rt_ok = (hz.id_rt != '0);
`else
    assign rs_ok = 1'b1;
    assign rt_ok = 1'b1;
`endif

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (slots[k].valid &&
                ((hz.id_uses_rs && rs_ok && slots[k].rd == hz.id_rs) ||
                 (hz.id_uses_rt && rt_ok && slots[k].rd == hz.id_rt)))
                hazard = 1'b1;
        end
        hazard = hazard && hz.id_valid;
    end

    // Reset forces RUN even if freeze or flush requests are present.
    always_comb begin
        mode = MODE_RUN;
        if (reset)                   mode = MODE_RUN;
        else if (hz.mem_busy)        mode = MODE_FREEZE;
        else if (hz.ex_branch_taken) mode = MODE_FLUSH;
        else if (hazard)             mode = MODE_STALL;
    end

    always_comb begin
        hz.pc_write    = 1'b1;
        hz.if_id_write = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_write = 1'b1;
        hz.id_ex_flush = 1'b0;
        unique case (mode)
            MODE_FREEZE: begin
                hz.pc_write    = 1'b0;
                hz.if_id_write = 1'b0;
                hz.id_ex_write = 1'b0;
            end
            MODE_FLUSH: begin
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end
            MODE_STALL: begin
                hz.pc_write    = 1'b0;
                hz.if_id_write = 1'b0;
                hz.id_ex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    // Only an instruction actually advancing into EX enters the scoreboard; stalls and flushes insert bubbles.
    always_comb begin
        new_entry.rd    = hz.id_rd;
        new_entry.valid = (mode == MODE_RUN) && hz.id_valid && hz.id_is_load;
`ifdef HAZ_ZERO_REG_EN
        if (hz.id_rd == '0) new_entry.valid = 1'b0;
`endif
    end

    // NOTE: the scoreboard slots are control state, so unlike a data RAM they must be cleared by reset.
    // NOTE: sequential state uses non-blocking assignments so every slot samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LOAD_LAT; k++) slots[k] <= '0;
        end else if (mode != MODE_FREEZE) begin
            slots[0] <= new_entry;
            for (int k = 1; k < LOAD_LAT; k++) slots[k] <= slots[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (mode == MODE_STALL && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign hz.load_stall_cnt = stall_cnt;
endmodule
